vending_ctrl_multi: RTL and testbench
=====================================

# vending_ctrl_multi

Parametrised multi-product vending controller, successor to the single-product controller in the vending datapath. It accumulates coin credit, vends one of `N_PROD` selectable products against per-product prices and stock flags, returns change, and refunds on cancel or inactivity timeout. It keeps a running sales total. It sits between the coin acceptor / button front-end and the dispenser and change-hopper drivers.

## Interface
- `VAL_W`, 8: width of coin values, prices, credit and change
- `N_PROD`, 4: number of products (≥2); `SEL_W = $clog2(N_PROD)`
- `SALES_W`, 16: width of the sales accumulator
- `TIMEOUT_CYC`, 1000: idle cycles in CREDIT before auto-refund (≥2)
- `ALARM_CYC`, 8: cycles the alarm is held (≥1)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `coin_valid`  in  1  one-cycle strobe: coin inserted
- `coin_value`  in  VAL_W  value of the inserted coin, sampled with `coin_valid`
- `confirm`  in  1  one-cycle strobe: purchase request
- `cancel`  in  1  one-cycle strobe: refund request
- `sel`  in  SEL_W  product index, sampled with `confirm`
- `price`  in  N_PROD*VAL_W  packed prices; product i at `[i*VAL_W +: VAL_W]`
- `stock_empty`  in  N_PROD  per-product sold-out flags
- `credit`  out  VAL_W  current credit
- `coin_reject`  out  1  one-cycle pulse: coin not accepted
- `dispense_valid`  out  1  one-cycle pulse: vend product `dispense_id`
- `dispense_id`  out  SEL_W  product being vended
- `change_valid`  out  1  one-cycle pulse: return `change`
- `change`  out  VAL_W  change/refund amount; held until the next `change_valid`
- `alarm`  out  1  purchase refused, held `ALARM_CYC` cycles
- `total_sales`  out  SALES_W  cumulative sold value, wraps modulo 2^SALES_W

## Operation
- States: IDLE, CREDIT, VEND, ALARM. Reset enters IDLE.
- Reset values are 0 for all outputs, the timeout counter and the alarm counter.
- IDLE:
  - `coin_valid` → credit = `coin_value`, go to CREDIT.
  - `confirm` and `cancel` are ignored.
  - A zero-value coin is rejected (`coin_reject`).
- CREDIT: events are prioritised cancel > confirm > coin.
  - `cancel`: `change` = credit, `change_valid`, credit ← 0, go to IDLE.
  - `confirm`, `stock_empty[sel]=0` and credit ≥ `price[sel]`: latch `sel`, go to VEND.
  - `confirm` failing either check: `alarm`←1, go to ALARM. Credit is kept.
  - `coin_valid` alone: credit += `coin_value`. If the sum exceeds 2^VAL_W−1, the coin is rejected and credit is unchanged.
  - A coin arriving in the same cycle as an accepted cancel or confirm is rejected.
  - `sel` ≥ N_PROD counts as a failed confirm.
  - Timeout: the counter resets on any accepted coin, confirm or cancel and increments otherwise. At `TIMEOUT_CYC` idle cycles the block refunds exactly as for cancel.
- VEND (1 cycle):
  - Pulse `dispense_valid` with `dispense_id` = latched sel.
  - `total_sales` += price.
  - If credit − price > 0: `change` = remainder with `change_valid`.
  - credit ← 0, go to IDLE.
  - Coins are rejected.
- ALARM:
  - `alarm` is held for `ALARM_CYC` cycles, then cleared; return to CREDIT with the timeout counter cleared.
  - Coins are rejected. `cancel` aborts the alarm and refunds as in CREDIT.
- `price` and `stock_empty` are sampled only in the confirm cycle.
- Arithmetic: the credit sum is computed at VAL_W+1 bits for overflow detection. The sales sum is zero-extended and wraps.

## Timing
- Coin → `credit` updated on the next edge (1-cycle latency).
- Accepted `confirm` at edge k → `dispense_valid`, `change_valid` and the `total_sales` update at edge k+1. The block is ready for a coin at k+2.
- Cancel or timeout → `change_valid` on the next edge.
- Failed confirm at edge k → `alarm` high over cycles k+1 … k+ALARM_CYC; CREDIT at k+ALARM_CYC+1.
- `coin_reject` is asserted in the cycle after the rejected strobe.
- Reset mid-operation clears everything asynchronously. Credit is lost and no refund is issued.

## Structure
- The shared package `vend_pkg` holds:
  - the state enum `vend_state_t` (IDLE, CREDIT, VEND, ALARM);
  - default parameter constants;
  - a `price_of(price, idx)` slice function.
- One sub-module, `vend_timeout_cnt`: a loadable idle counter with clear and expiry pulse, reused for the alarm hold.
- The FSM and datapath live in `vending_ctrl_multi`.

## Test plan
- Defaults. Coins 5, 10 → credit 15. confirm sel=2 with price[2]=12 → `dispense_valid`, id 2, `change`=3, `total_sales`=12, back to IDLE.
- credit 5, confirm sel=1 with price=9 → `alarm` high for exactly 8 cycles, credit stays 5. Then coin 4 and confirm → vend, `change`=0 and no `change_valid`.
- `stock_empty[3]`=1, credit 50, confirm sel=3 → alarm. Then cancel → `change`=50, credit 0.
- credit 250, coin 10 → `coin_reject`, credit 250. Same-cycle coin+confirm → vend, and the coin is rejected.
- credit 7, no activity for 1000 cycles → `change_valid`, `change`=7, IDLE. With `SALES_W`=8, sales of 200+100 → `total_sales`=44.
- `rst_n` low during VEND and during ALARM → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, default parameters and helpers for the multi-product vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    ALARM  = 2'd3
  } vend_state_t;

  localparam int unsigned DEF_VAL_W       = 8;
  localparam int unsigned DEF_N_PROD      = 4;
  localparam int unsigned DEF_SALES_W     = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000;
  localparam int unsigned DEF_ALARM_CYC   = 8;

  // Upper bounds for the generic price slicer; callers zero-extend into these widths.
  localparam int unsigned PRICE_MAX_W = 256;
  localparam int unsigned VAL_MAX_W   = 32;

  function automatic logic [VAL_MAX_W-1:0] price_of(input logic [PRICE_MAX_W-1:0] price,
                                                    input int unsigned idx,
                                                    input int unsigned val_w);
    return VAL_MAX_W'(price >> (idx * val_w));
  endfunction

endpackage

// File: rtl/vend_timeout_cnt.sv
// Loadable idle counter with clear; expire_c_o flags the LIMIT-th counted cycle.
module vend_timeout_cnt #(
  parameter  int unsigned LIMIT = 2,
  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + CNT_W'(1);
  end

  assign expire_c_o = en_i && !clr_i && !load_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: coin credit, priced/stocked vend, change,
// cancel/timeout refund, refusal alarm and running sales total.
module vending_ctrl_multi
  import vend_pkg::*;
#(
  parameter  int unsigned VAL_W       = DEF_VAL_W,
  parameter  int unsigned N_PROD      = DEF_N_PROD,
  parameter  int unsigned SALES_W     = DEF_SALES_W,
  parameter  int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter  int unsigned ALARM_CYC   = DEF_ALARM_CYC,
  localparam int unsigned SEL_W       = $clog2(N_PROD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coin_valid,
  input  logic [VAL_W-1:0]        coin_value,
  input  logic                    confirm,
  input  logic                    cancel,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_PROD*VAL_W-1:0] price,
  input  logic [N_PROD-1:0]       stock_empty,
  output logic [VAL_W-1:0]        credit,
  output logic                    coin_reject,
  output logic                    dispense_valid,
  output logic [SEL_W-1:0]        dispense_id,
  output logic                    change_valid,
  output logic [VAL_W-1:0]        change,
  output logic                    alarm,
  output logic [SALES_W-1:0]      total_sales
);

  vend_state_t        state_q, state_d;
  logic [VAL_W-1:0]   credit_q, credit_d;
  logic [VAL_W-1:0]   change_q, change_d;
  logic [VAL_W-1:0]   vprice_q, vprice_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   dispense_id_q, dispense_id_d;
  logic [SALES_W-1:0] total_sales_q, total_sales_d;
  logic               coin_reject_q, coin_reject_d;
  logic               dispense_valid_q, dispense_valid_d;
  logic               change_valid_q, change_valid_d;
  logic               alarm_q, alarm_d;

  logic [VAL_W:0]     sum_c;
  logic [VAL_W-1:0]   sel_price_c;
  logic [VAL_W-1:0]   remain_c;
  logic               sel_ok_c, sel_empty_c, buy_ok_c;
  logic               to_clr_c, to_expire_c, al_expire_c;

  // Credit sum carries one extra bit so overflow is visible.
  assign sum_c       = (VAL_W+1)'(credit_q) + (VAL_W+1)'(coin_value);
  assign sel_ok_c    = (32'(sel) < N_PROD);
  assign sel_empty_c = sel_ok_c ? stock_empty[sel] : 1'b1;
  assign sel_price_c = VAL_W'(price_of(PRICE_MAX_W'(price), 32'(sel), VAL_W));
  assign buy_ok_c    = sel_ok_c && !sel_empty_c && (credit_q >= sel_price_c);
  assign remain_c    = credit_q - vprice_q;

  // Inactivity timer only runs in CREDIT and restarts on any accepted event.
  assign to_clr_c = (state_q != CREDIT) || cancel || confirm ||
                    (coin_valid && !sum_c[VAL_W]);

  vend_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_idle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (to_clr_c),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == CREDIT),
    .expire_c_o (to_expire_c)
  );

  vend_timeout_cnt #(.LIMIT(ALARM_CYC)) u_alarm_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q != ALARM),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == ALARM),
    .expire_c_o (al_expire_c)
  );

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    change_d         = change_q;
    vprice_d         = vprice_q;
    sel_d            = sel_q;
    dispense_id_d    = dispense_id_q;
    total_sales_d    = total_sales_q;
    coin_reject_d    = 1'b0;
    dispense_valid_d = 1'b0;
    change_valid_d   = 1'b0;
    alarm_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_valid) begin
          if (coin_value == '0) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_value;
            state_d  = CREDIT;
          end
        end
      end

      CREDIT: begin
        if (cancel) begin
          coin_reject_d  = coin_valid;
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = '0;
          state_d        = IDLE;
        end else if (confirm) begin
          coin_reject_d = coin_valid;
          if (buy_ok_c) begin
            sel_d    = sel;
            vprice_d = sel_price_c;
            state_d  = VEND;
          end else begin
            alarm_d = 1'b1;
            state_d = ALARM;
          end
        end else if (coin_valid) begin
          if (sum_c[VAL_W]) coin_reject_d = 1'b1;
          else              credit_d      = VAL_W'(sum_c);
        end else if (to_expire_c) begin
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = '0;
          state_d        = IDLE;
        end
      end

      VEND: begin
        coin_reject_d    = coin_valid;
        dispense_valid_d = 1'b1;
        dispense_id_d    = sel_q;
        total_sales_d    = total_sales_q + SALES_W'(vprice_q);
        if (remain_c != '0) begin
          change_d       = remain_c;
          change_valid_d = 1'b1;
        end
        credit_d = '0;
        state_d  = IDLE;
      end

      ALARM: begin
        coin_reject_d = coin_valid;
        if (cancel) begin
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = '0;
          state_d        = IDLE;
        end else if (al_expire_c) begin
          state_d = CREDIT;
        end else begin
          alarm_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      credit_q         <= '0;
      change_q         <= '0;
      vprice_q         <= '0;
      sel_q            <= '0;
      dispense_id_q    <= '0;
      total_sales_q    <= '0;
      coin_reject_q    <= 1'b0;
      dispense_valid_q <= 1'b0;
      change_valid_q   <= 1'b0;
      alarm_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      change_q         <= change_d;
      vprice_q         <= vprice_d;
      sel_q            <= sel_d;
      dispense_id_q    <= dispense_id_d;
      total_sales_q    <= total_sales_d;
      coin_reject_q    <= coin_reject_d;
      dispense_valid_q <= dispense_valid_d;
      change_valid_q   <= change_valid_d;
      alarm_q          <= alarm_d;
    end
  end

  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_id    = dispense_id_q;
  assign change_valid   = change_valid_q;
  assign change         = change_q;
  assign alarm          = alarm_q;
  assign total_sales    = total_sales_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Directed self-checking bench for vending_ctrl_multi (8-bit sales total to exercise wrap).
module tb_vending_ctrl_multi;

  localparam int unsigned VAL_W       = 8;
  localparam int unsigned N_PROD      = 4;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned SALES_W     = 8;
  localparam int unsigned TIMEOUT_CYC = 1000;
  localparam int unsigned ALARM_CYC   = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    coin_valid;
  logic [VAL_W-1:0]        coin_value;
  logic                    confirm;
  logic                    cancel;
  logic [SEL_W-1:0]        sel;
  logic [N_PROD*VAL_W-1:0] price;
  logic [N_PROD-1:0]       stock_empty;
  logic [VAL_W-1:0]        credit;
  logic                    coin_reject;
  logic                    dispense_valid;
  logic [SEL_W-1:0]        dispense_id;
  logic                    change_valid;
  logic [VAL_W-1:0]        change;
  logic                    alarm;
  logic [SALES_W-1:0]      total_sales;

  int n_cmp = 0;
  int n_bad = 0;

  vending_ctrl_multi #(
    .VAL_W(VAL_W), .N_PROD(N_PROD), .SALES_W(SALES_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .ALARM_CYC(ALARM_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .confirm(confirm), .cancel(cancel), .sel(sel), .price(price),
    .stock_empty(stock_empty), .credit(credit), .coin_reject(coin_reject),
    .dispense_valid(dispense_valid), .dispense_id(dispense_id),
    .change_valid(change_valid), .change(change), .alarm(alarm),
    .total_sales(total_sales)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [VAL_W-1:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick();
    coin_valid = 1'b0; coin_value = '0;
  endtask

  task automatic do_confirm(input logic [SEL_W-1:0] s);
    confirm = 1'b1; sel = s;
    tick();
    confirm = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (credit !== 8'd0) begin n_bad++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_cmp++; if ({coin_reject, dispense_valid, change_valid, alarm} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 0000", {coin_reject, dispense_valid, change_valid, alarm}); end
    n_cmp++; if ({change, total_sales, dispense_id} !== '0) begin
      n_bad++; $display("FAIL reset_values: change %0d sales %0d id %0d want 0", change, total_sales, dispense_id); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vend_change();
    put_coin(8'd5);
    n_cmp++; if (credit !== 8'd5) begin n_bad++; $display("FAIL coin5_credit: got %0d want 5", credit); end
    put_coin(8'd10);
    n_cmp++; if (credit !== 8'd15) begin n_bad++; $display("FAIL coin10_credit: got %0d want 15", credit); end
    do_confirm(2'd2);
    n_cmp++; if (dispense_valid !== 1'b0) begin n_bad++; $display("FAIL vend_early: got %b want 0", dispense_valid); end
    tick();
    n_cmp++; if (dispense_valid !== 1'b1 || dispense_id !== 2'd2) begin
      n_bad++; $display("FAIL vend_pulse: valid %b id %0d want 1 id 2", dispense_valid, dispense_id); end
    n_cmp++; if (change_valid !== 1'b1 || change !== 8'd3) begin
      n_bad++; $display("FAIL vend_change: valid %b change %0d want 1 change 3", change_valid, change); end
    n_cmp++; if (total_sales !== 8'd12 || credit !== 8'd0) begin
      n_bad++; $display("FAIL vend_sales: sales %0d credit %0d want 12 and 0", total_sales, credit); end
    tick();
    n_cmp++; if (dispense_valid !== 1'b0 || change_valid !== 1'b0) begin
      n_bad++; $display("FAIL vend_one_shot: dv %b cv %b want 0 0", dispense_valid, change_valid); end
    put_coin(8'd0);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      n_bad++; $display("FAIL zero_coin: reject %b credit %0d want 1 0", coin_reject, credit); end
    do_confirm(2'd0);
    tick();
    n_cmp++; if (alarm !== 1'b0 || dispense_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_confirm: alarm %b dv %b want 0 0", alarm, dispense_valid); end
  endtask

  task automatic test_alarm_retry();
    int cnt;
    put_coin(8'd5);
    do_confirm(2'd1);
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_set: got %b want 1", alarm); end
    cnt = 1;
    put_coin(8'd3);
    n_cmp++; if (coin_reject !== 1'b1) begin n_bad++; $display("FAIL alarm_coin: got %b want 1", coin_reject); end
    if (alarm) cnt++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (alarm) cnt++;
      else break;
    end
    n_cmp++; if (cnt != 8) begin n_bad++; $display("FAIL alarm_len: got %0d want 8", cnt); end
    n_cmp++; if (credit !== 8'd5) begin n_bad++; $display("FAIL alarm_credit: got %0d want 5", credit); end
    put_coin(8'd4);
    n_cmp++; if (credit !== 8'd9) begin n_bad++; $display("FAIL retry_credit: got %0d want 9", credit); end
    do_confirm(2'd1);
    tick();
    n_cmp++; if (dispense_valid !== 1'b1 || change_valid !== 1'b0 || dispense_id !== 2'd1) begin
      n_bad++; $display("FAIL exact_vend: dv %b cv %b id %0d want 1 0 1", dispense_valid, change_valid, dispense_id); end
    n_cmp++; if (total_sales !== 8'd21) begin n_bad++; $display("FAIL exact_sales: got %0d want 21", total_sales); end
    tick();
  endtask

  task automatic test_stock_cancel();
    stock_empty = 4'b1000;
    put_coin(8'd50);
    do_confirm(2'd3);
    n_cmp++; if (alarm !== 1'b1 || dispense_valid !== 1'b0) begin
      n_bad++; $display("FAIL soldout_alarm: alarm %b dv %b want 1 0", alarm, dispense_valid); end
    do_cancel();
    n_cmp++; if (change_valid !== 1'b1 || change !== 8'd50) begin
      n_bad++; $display("FAIL cancel_refund: cv %b change %0d want 1 50", change_valid, change); end
    n_cmp++; if (credit !== 8'd0 || alarm !== 1'b0) begin
      n_bad++; $display("FAIL cancel_clear: credit %0d alarm %b want 0 0", credit, alarm); end
    stock_empty = '0;
    tick();
  endtask

  task automatic test_overflow();
    put_coin(8'd250);
    put_coin(8'd10);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd250) begin
      n_bad++; $display("FAIL ovf_reject: reject %b credit %0d want 1 250", coin_reject, credit); end
    put_coin(8'd5);
    n_cmp++; if (coin_reject !== 1'b0 || credit !== 8'd255) begin
      n_bad++; $display("FAIL max_credit: reject %b credit %0d want 0 255", coin_reject, credit); end
    put_coin(8'd1);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd255) begin
      n_bad++; $display("FAIL ovf_by_one: reject %b credit %0d want 1 255", coin_reject, credit); end
    coin_valid = 1'b1; coin_value = 8'd5; confirm = 1'b1; sel = 2'd3;
    tick();
    coin_valid = 1'b0; coin_value = '0; confirm = 1'b0;
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd255) begin
      n_bad++; $display("FAIL coin_confirm: reject %b credit %0d want 1 255", coin_reject, credit); end
    tick();
    n_cmp++; if (dispense_valid !== 1'b1 || change !== 8'd215 || total_sales !== 8'd61) begin
      n_bad++; $display("FAIL coin_confirm_vend: dv %b change %0d sales %0d want 1 215 61", dispense_valid, change, total_sales); end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    put_coin(8'd7);
    early = 0;
    for (int i = 0; i < int'(TIMEOUT_CYC) - 1; i++) begin
      tick();
      if (change_valid) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL timeout_early: got %0d pulses want 0", early); end
    tick();
    n_cmp++; if (change_valid !== 1'b1 || change !== 8'd7 || credit !== 8'd0) begin
      n_bad++; $display("FAIL timeout_refund: cv %b change %0d credit %0d want 1 7 0", change_valid, change, credit); end
    tick();
  endtask

  task automatic test_reset_midop();
    put_coin(8'd20);
    do_confirm(2'd2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (credit !== 8'd0 || total_sales !== 8'd0 || change !== 8'd0) begin
      n_bad++; $display("FAIL rst_vend: credit %0d sales %0d change %0d want 0 0 0", credit, total_sales, change); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dispense_valid !== 1'b0 || change_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_vend_after: dv %b cv %b want 0 0", dispense_valid, change_valid); end
    put_coin(8'd5);
    do_confirm(2'd1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (alarm !== 1'b0 || credit !== 8'd0) begin
      n_bad++; $display("FAIL rst_alarm: alarm %b credit %0d want 0 0", alarm, credit); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if (alarm !== 1'b0 || change_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_alarm_after: alarm %b cv %b want 0 0", alarm, change_valid); end
  endtask

  task automatic test_back_to_back();
    price = {8'd40, 8'd12, 8'd100, 8'd200};
    put_coin(8'd200);
    do_confirm(2'd0);
    tick();
    n_cmp++; if (total_sales !== 8'd200) begin n_bad++; $display("FAIL sales_200: got %0d want 200", total_sales); end
    put_coin(8'd100);
    n_cmp++; if (coin_reject !== 1'b0 || credit !== 8'd100) begin
      n_bad++; $display("FAIL b2b_coin: reject %b credit %0d want 0 100", coin_reject, credit); end
    do_confirm(2'd1);
    tick();
    n_cmp++; if (total_sales !== 8'd44 || change_valid !== 1'b0) begin
      n_bad++; $display("FAIL sales_wrap: sales %0d cv %b want 44 0", total_sales, change_valid); end
    tick();
  endtask

  initial begin
    coin_valid  = 1'b0;
    coin_value  = '0;
    confirm     = 1'b0;
    cancel      = 1'b0;
    sel         = '0;
    stock_empty = '0;
    price       = {8'd40, 8'd12, 8'd9, 8'd5};
    test_reset();
    test_vend_change();
    test_alarm_retry();
    test_stock_cancel();
    test_overflow();
    test_timeout();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
